uart_tx_buffer: RTL
===================

UART_TX_BUFFER -- requirements
Module: uart_tx_buffer

Interface
REQ-001 SHALL have parameter CLK_PER_BIT, default 868, clock cycles per UART bit (100 MHz / 115200); legal range 2..65535.
REQ-002 SHALL have parameter FIFO_DEPTH, default 16, byte entries buffered; power of two, 2..256.
REQ-003 SHALL use one clock; reset is asynchronous and active-low; ports named clk and rstn.
REQ-004 clk  input  1  system clock, all state on rising edge.
REQ-005 rstn  input  1  asynchronous active-low reset.
REQ-006 sdata  input  8  byte from core transmit instruction, valid when tx_ready=1.
REQ-007 tx_ready  input  1  one-cycle push strobe from core (core never stalls).
REQ-008 txd  output  1  serial line, 8N1, idle high.
REQ-009 busy  output  1  high while FIFO non-empty or a frame is on the line.
REQ-010 full  output  1  FIFO occupancy == FIFO_DEPTH.
REQ-011 overflow  output  1  sticky flag, a push was dropped.

Function
REQ-012 SHALL accept a push on a rising edge with tx_ready=1 if occupancy < FIFO_DEPTH or a pop occurs on the same edge.
REQ-013 SHALL drop a push when full with no same-edge pop, leave FIFO unchanged, set overflow=1 until reset.
REQ-014 SHALL keep FIFO order strictly first-in first-out; read/write pointers wrap modulo FIFO_DEPTH; occupancy counter width clog2(FIFO_DEPTH)+1.
REQ-015 SHALL implement serializer FSM states IDLE, START, DATA, STOP.
REQ-016 IDLE: txd=1; if FIFO non-empty, pop head into 8-bit shift register, clear bit counter and baud counter, go START.
REQ-017 START: txd=0 for exactly CLK_PER_BIT cycles, then DATA.
REQ-018 DATA: drive shift register bit 0, LSB first, each bit exactly CLK_PER_BIT cycles; after bit 7, go STOP.
REQ-019 STOP: txd=1 for exactly CLK_PER_BIT cycles, then IDLE.
REQ-020 txd SHALL be a registered output, glitch-free.
REQ-021 Latency: push at edge N into empty FIFO with FSM in IDLE, txd falls after edge N+1 (pop at N+1).
REQ-022 Back-to-back frames SHALL be separated by exactly one IDLE cycle (stop period CLK_PER_BIT+1 cycles) when FIFO non-empty.
REQ-023 Baud counter SHALL count 0..CLK_PER_BIT-1 and reload at each bit boundary; no drift across frames.
REQ-024 busy SHALL be (state != IDLE) or (occupancy != 0), combinational from registers.
REQ-025 Simultaneous push and pop on an empty FIFO is impossible (pop requires non-empty); the push SHALL simply be stored.

Reset
REQ-026 On rstn=0, asynchronously: txd=1, state=IDLE, FIFO pointers and occupancy=0, overflow=0, busy=0, full=0, counters=0.
REQ-027 Reset mid-frame SHALL abort the frame, raise txd immediately, and discard all buffered bytes.
REQ-028 FIFO storage array need not be reset.

Structure
REQ-029 Shared package SHALL hold FSM state encoding localparams (IDLE/START/DATA/STOP) and default CLK_PER_BIT.
REQ-030 SHALL instantiate one sub-module tx_fifo (synchronous FIFO: push, pop, din, dout, full, empty, count); serializer FSM lives in uart_tx_buffer.

Verification (CLK_PER_BIT=4, FIFO_DEPTH=4)
REQ-031 Single byte 0x55 pushed at edge N -> txd low after edge N+1 for 4 cycles, then 1,0,1,0,1,0,1,0 each 4 cycles, then high 4 cycles; busy low after frame end.
REQ-032 Push 0x01,0x80 on consecutive cycles -> two frames in order, exactly one idle cycle between stop bit of first and start bit of second.
REQ-033 Six pushes 0xA0..0xA5 on consecutive cycles -> FIFO takes four plus one after first pop; 0xA5 dropped, overflow=1 and stays 1; line emits 0xA0..0xA4 only.
REQ-034 Push when full on the same edge the serializer pops -> push accepted, overflow stays 0, full stays 1.
REQ-035 Assert rstn=0 during DATA bit 3 of 0xFF with two bytes queued -> txd=1 immediately, busy=0, no further frames after release.
REQ-036 Idle with no pushes for 100 cycles after reset -> txd constant 1, busy=0, full=0, overflow=0.

Source files
------------

// File: rtl/uart_tx_buffer_pkg.sv
// Shared definitions for the buffered UART transmitter: serializer state
// encoding, framing constants and default parameter values.
package uart_tx_buffer_pkg;

    // Serializer state encoding.
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        START = ST_START,
        DATA  = ST_DATA,
        STOP  = ST_STOP
    } tx_state_t;

    // 100 MHz system clock, 115200 baud.
    localparam int unsigned DEFAULT_CLK_PER_BIT = 868;
    localparam int unsigned DEFAULT_FIFO_DEPTH  = 16;

    // 8N1 framing: eight data bits per frame.
    localparam int unsigned DATA_BITS = 8;

endpackage

// File: rtl/uart_tx_buffer_fifo.sv
// Synchronous first-word-fall-through FIFO feeding the UART serializer.
// A push is accepted when not full, or when a pop happens on the same edge.
module tx_fifo
    import uart_tx_buffer_pkg::*;
#(
    parameter int unsigned DEPTH = DEFAULT_FIFO_DEPTH,
    parameter int unsigned WIDTH = DATA_BITS
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);
    assign dout  = mem[rd_ptr];

    // Storage write port.
    // NOTE: the data array is deliberately left out of reset; only the
    // pointers and occupancy decide what is valid, and an unreset array maps
    // onto plain RAM/flops without reset fan-out.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap naturally since DEPTH
    // is a power of two.
    // NOTE: non-blocking assignments keep every register sampling the
    // pre-edge values, so count and the pointers update consistently.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_buffer.sv
// Buffered 8N1 UART transmitter: bytes pushed by the core are queued in a
// small FIFO and shifted out LSB first on a registered, idle-high txd line.
module uart_tx_buffer
    import uart_tx_buffer_pkg::*;
#(
    parameter int unsigned CLK_PER_BIT = DEFAULT_CLK_PER_BIT,
    parameter int unsigned FIFO_DEPTH  = DEFAULT_FIFO_DEPTH
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic [7:0] sdata,
    input  logic       tx_ready,
    output logic       txd,
    output logic       busy,
    output logic       full,
    output logic       overflow
);

    localparam int unsigned BAUD_W = (CLK_PER_BIT > 1) ? $clog2(CLK_PER_BIT) : 1;
    localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH) + 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLK_PER_BIT - 1);
    localparam logic [2:0]        BIT_LAST  = 3'(DATA_BITS - 1);

    tx_state_t         state;
    logic [7:0]        shreg;
    logic [2:0]        bit_cnt;
    logic [BAUD_W-1:0] baud_cnt;

    logic              pop;
    logic              fifo_empty;
    logic [7:0]        fifo_dout;
    logic [CNT_W-1:0]  fifo_count;

    // The serializer only takes a byte while idle, so a pop never meets an
    // empty FIFO.
    assign pop  = (state == IDLE) && !fifo_empty;
    assign busy = (state != IDLE) || (fifo_count != '0);

    tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk   (clk),
        .rstn  (rstn),
        .push  (tx_ready),
        .pop   (pop),
        .din   (sdata),
        .dout  (fifo_dout),
        .full  (full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Sticky flag: a push arrived while full with no pop to make room.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            overflow <= 1'b0;
        end else if (tx_ready && full && !pop) begin
            overflow <= 1'b1;
        end
    end

    // Serializer: each state holds txd for CLK_PER_BIT cycles; txd is set one
    // edge ahead so the line value is always a flop output.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= IDLE;
            txd      <= 1'b1;
            shreg    <= '0;
            bit_cnt  <= '0;
            baud_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    txd <= 1'b1;
                    if (!fifo_empty) begin
                        shreg    <= fifo_dout;
                        bit_cnt  <= '0;
                        baud_cnt <= '0;
                        txd      <= 1'b0;
                        state    <= START;
                    end
                end
                START: begin
                    if (baud_cnt == BAUD_LAST) begin
                        baud_cnt <= '0;
                        txd      <= shreg[0];
                        state    <= DATA;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (baud_cnt == BAUD_LAST) begin
                        baud_cnt <= '0;
                        if (bit_cnt == BIT_LAST) begin
                            txd   <= 1'b1;
                            state <= STOP;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                            shreg   <= shreg >> 1;
                            txd     <= shreg[1];
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (baud_cnt == BAUD_LAST) begin
                        baud_cnt <= '0;
                        state    <= IDLE;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                default: begin
                    txd   <= 1'b1;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
